kbd_cmd_sequencer: RTL and testbench
====================================

Name: kbd_cmd_sequencer

Overview:
Host-to-keyboard command sequencer for the PS/2 keyboard path. It sits between the byte receiver and the scancode decoder, and drives a byte-level PS/2 transmitter. It accepts one command at a time (optionally with one argument byte) and sends the bytes in order. It waits for ACK, BAT-complete or resend, applies retry and timeout policy, and strips protocol response bytes from the scancode stream.

Parameters:
ACK_TIMEOUT, 1_000_000, cycles allowed from tx byte acceptance to ACK/RESEND (20 ms at 50 MHz)
BAT_TIMEOUT, 50_000_000, cycles allowed from reset-command ACK to BAT result (1 s at 50 MHz)
MAX_RETRIES, 3, resend/timeout retries per byte before error

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command request valid
cmd_ready_o  out  1  sequencer idle, request accepted on valid&ready
cmd_i  in  8  command byte (e.g. FF reset, ED set LEDs)
arg_i  in  8  argument byte
has_arg_i  in  1  send arg_i after command ACK
tx_data_o  out  8  byte to ps2 transmitter
tx_valid_o  out  1  transmit request
tx_ready_i  in  1  transmitter accepts byte on valid&ready
rx_data_i  in  8  byte from ps2_rx
rx_valid_i  in  1  rx byte strobe (1 cycle)
fwd_data_o  out  8  filtered byte to ps2_kbd
fwd_valid_o  out  1  filtered byte strobe
busy_o  out  1  command in progress
done_o  out  1  1-cycle pulse, command completed successfully
error_o  out  1  1-cycle pulse, command failed
error_code_o  out  2  kbd_cmd_err_t, held until next command accepted

Behaviour:
- Reset: state IDLE; cmd_ready_o=1; tx_valid_o, fwd_valid_o, busy_o, done_o, error_o = 0; error_code_o=ERR_NONE; retry and timer counters = 0.
- cmd_ready_o=1 only in IDLE. On acceptance, latch cmd/arg/has_arg, clear retry count and error_code, and go to SEND_CMD next cycle. busy_o=1 in every state except IDLE.
- SEND_CMD / SEND_ARG:
  - tx_valid_o=1 with the latched byte, held stable until tx_ready_i.
  - On handshake: load the timer with ACK_TIMEOUT and go to WAIT_CMD_ACK or WAIT_ARG_ACK.
- WAIT_*_ACK, on rx_valid_i:
  - FA: in WAIT_CMD_ACK, go to SEND_ARG if has_arg, else WAIT_BAT if cmd==FF, else DONE. In WAIT_ARG_ACK, go to DONE. Retry count clears on every ACK.
  - FE: if retries<MAX_RETRIES, increment retries and return to the same SEND state. Otherwise go to ERROR with ERR_RETRIES.
- Timer expiry (counter reaches 0) in a WAIT state is handled like FE. If retries are exhausted, ERROR uses ERR_TIMEOUT instead.
- WAIT_BAT:
  - Timer is loaded with BAT_TIMEOUT on entry.
  - AA goes to DONE; FC goes to ERROR with ERR_BAT.
  - Timeout goes to ERROR with ERR_TIMEOUT; there is no retry.
- DONE: done_o=1 for one cycle, then IDLE. ERROR: error_o=1 for one cycle, error_code_o set, then IDLE.
- Filtering:
  - A byte consumed by a transition above (FA/FE in WAIT_*_ACK, AA/FC in WAIT_BAT) is not forwarded.
  - Every other rx byte, in any state including IDLE, is forwarded with exactly 1-cycle latency: fwd_data_o registered, fwd_valid_o pulses 1 cycle.
  - FA/FE/AA received in IDLE or SEND states are forwarded.
- Simultaneous events:
  - An rx byte and timer expiry in the same cycle: the rx byte wins.
  - cmd_valid_i during busy is ignored; the requester holds it.
  - A byte arriving on the cycle of the tx handshake is evaluated in the SEND state, so it is forwarded.
- Timer is a down-counter sized $clog2(max timeout)+1. It is idle (no count) outside WAIT states.
- reset_i mid-command aborts immediately: tx_valid_o drops the next cycle, and no done/error pulse is generated.

Decomposition:
- Package common gains:
  - kbd_cmd_err_t enum {ERR_NONE, ERR_TIMEOUT, ERR_RETRIES, ERR_BAT}
  - constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_BAT_OK=8'hAA, PS2_BAT_FAIL=8'hFC, KBD_CMD_RESET=8'hFF, KBD_CMD_SET_LEDS=8'hED
  - the sequencer state enum
- No sub-module; the timer is inline. The ps2_tx bit engine is a separate sibling block, not part of this module.

Test Plan:
- Set LEDs: cmd=ED, arg=07, has_arg=1 → tx ED; rx FA → tx 07; rx FA → done_o pulse, error_code=ERR_NONE, zero fwd_valid_o pulses.
- Reset: cmd=FF, has_arg=0 → rx FA then AA → done_o. Repeat with FC instead of AA → error_o, ERR_BAT.
- Resend: cmd=F4 → rx FE twice → tx F4 three times total, then FA → done_o. Rx FE four times → error_o, ERR_RETRIES, and tx F4 sent exactly 4 times.
- Timeout: ACK_TIMEOUT=100, no rx → F4 retransmitted every ~100 cycles, 4 sends, then error_o with ERR_TIMEOUT.
- Interleave: rx 1C arrives during WAIT_CMD_ACK → fwd_data_o=1C, fwd_valid_o one cycle later, state unchanged; rx FA in IDLE → forwarded.
- Abort: assert reset_i in WAIT_ARG_ACK → next cycle IDLE, cmd_ready_o=1, tx_valid_o=0, no done/error pulse.

Source files
------------

// File: rtl/kbd_cmd_sequencer_pkg.sv
// kbd_cmd_sequencer_pkg: shared types and PS/2 protocol constants for the keyboard command sequencer
package kbd_cmd_sequencer_pkg;
  typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_RETRIES, ERR_BAT} kbd_cmd_err_t;
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_WAIT_CMD_ACK, S_SEND_ARG, S_WAIT_ARG_ACK, S_WAIT_BAT, S_DONE, S_ERROR
  } kbd_seq_state_t;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_RESEND       = 8'hFE;
  localparam logic [7:0] PS2_BAT_OK       = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL     = 8'hFC;
  localparam logic [7:0] KBD_CMD_RESET    = 8'hFF;
  localparam logic [7:0] KBD_CMD_SET_LEDS = 8'hED;
endpackage

// File: rtl/kbd_cmd_sequencer.sv
// kbd_cmd_sequencer: sends one host command (plus optional argument) to the keyboard,
// handles ACK/RESEND/BAT with retry and timeout, and strips consumed responses from the rx stream.
module kbd_cmd_sequencer
  import kbd_cmd_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int BAT_TIMEOUT = 50_000_000,
  parameter int MAX_RETRIES = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [7:0]   cmd_i,
  input  logic [7:0]   arg_i,
  input  logic         has_arg_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic [7:0]   fwd_data_o,
  output logic         fwd_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output kbd_cmd_err_t error_code_o
);
  localparam int TW = $clog2(ACK_TIMEOUT > BAT_TIMEOUT ? ACK_TIMEOUT : BAT_TIMEOUT) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 2);
  kbd_seq_state_t state;
  logic [7:0] cmd, arg;
  logic has_arg;
  logic [TW-1:0] timer;
  logic [RW-1:0] retries;
  logic wait_ack, expired, retry_ok, consumed, rx_ack, rx_resend, rx_bat_ok, rx_bat_fail;
  assign wait_ack    = state == S_WAIT_CMD_ACK || state == S_WAIT_ARG_ACK;
  assign expired     = timer == '0;
  assign retry_ok    = retries < RW'(MAX_RETRIES);
  assign rx_ack      = rx_valid_i && rx_data_i == PS2_ACK;
  assign rx_resend   = rx_valid_i && rx_data_i == PS2_RESEND;
  assign rx_bat_ok   = rx_valid_i && rx_data_i == PS2_BAT_OK;
  assign rx_bat_fail = rx_valid_i && rx_data_i == PS2_BAT_FAIL;
  assign consumed    = (wait_ack && (rx_ack || rx_resend)) || (state == S_WAIT_BAT && (rx_bat_ok || rx_bat_fail));
  // Handshake outputs decode straight from the state register, so they never see input paths
  assign cmd_ready_o = state == S_IDLE;
  assign busy_o      = state != S_IDLE;
  assign tx_valid_o  = state == S_SEND_CMD || state == S_SEND_ARG;
  assign tx_data_o   = state == S_SEND_ARG ? arg : cmd;
  assign done_o      = state == S_DONE;
  assign error_o     = state == S_ERROR;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      cmd          <= '0;
      arg          <= '0;
      has_arg      <= 1'b0;
      timer        <= '0;
      retries      <= '0;
      error_code_o <= ERR_NONE;
      fwd_valid_o  <= 1'b0;
      fwd_data_o   <= '0;
    end else begin
      fwd_valid_o <= rx_valid_i && !consumed;
      if (rx_valid_i) fwd_data_o <= rx_data_i;
      case (state)
        S_IDLE:
          if (cmd_valid_i) begin
            cmd          <= cmd_i;
            arg          <= arg_i;
            has_arg      <= has_arg_i;
            retries      <= '0;
            error_code_o <= ERR_NONE;
            state        <= S_SEND_CMD;
          end
        S_SEND_CMD, S_SEND_ARG:
          if (tx_ready_i) begin
            timer <= TW'(ACK_TIMEOUT);
            state <= state == S_SEND_CMD ? S_WAIT_CMD_ACK : S_WAIT_ARG_ACK;
          end
        S_WAIT_CMD_ACK, S_WAIT_ARG_ACK:
          if (rx_ack) begin
            retries <= '0;
            timer   <= TW'(BAT_TIMEOUT);
            state   <= state == S_WAIT_ARG_ACK ? S_DONE :
                       has_arg                 ? S_SEND_ARG :
                       cmd == KBD_CMD_RESET    ? S_WAIT_BAT : S_DONE;
          end else if (rx_resend || (!rx_valid_i && expired)) begin
            retries      <= retry_ok ? retries + 1'b1 : retries;
            error_code_o <= retry_ok ? error_code_o : rx_valid_i ? ERR_RETRIES : ERR_TIMEOUT;
            state        <= !retry_ok ? S_ERROR : state == S_WAIT_CMD_ACK ? S_SEND_CMD : S_SEND_ARG;
          end else if (!expired) begin
            timer <= timer - 1'b1;
          end
        S_WAIT_BAT:
          if (rx_bat_ok) begin
            state <= S_DONE;
          end else if (rx_bat_fail || (!rx_valid_i && expired)) begin
            error_code_o <= rx_bat_fail ? ERR_BAT : ERR_TIMEOUT;
            state        <= S_ERROR;
          end else if (!expired) begin
            timer <= timer - 1'b1;
          end
        S_DONE, S_ERROR:
          state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kbd_cmd_sequencer.sv
// tb_kbd_cmd_sequencer: directed and randomized checks of the command sequencer against a
// transaction-level keyboard model (per-byte attempt counting, expected tx/fwd byte lists).
module tb_kbd_cmd_sequencer;
  import kbd_cmd_sequencer_pkg::*;
  localparam int ACK_T = 100;
  localparam int BAT_T = 300;
  localparam int MAXR  = 3;
  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, has_arg, tx_valid, tx_ready, rx_valid, fwd_valid, busy, done, err;
  logic [7:0] cmd_byte, arg_byte, tx_data, rx_data, fwd_data;
  kbd_cmd_err_t error_code;
  int total = 0, bad = 0, cyc = 0;
  int n_tx = 0, n_done = 0, n_err = 0, last_tx_cyc = 0, last_err_cyc = 0;
  logic [7:0] obs_tx[$], obs_fwd[$];
  int script[$];
  kbd_cmd_sequencer #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRIES(MAXR)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_i(cmd_byte), .arg_i(arg_byte), .has_arg_i(has_arg), .tx_data_o(tx_data),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .fwd_data_o(fwd_data), .fwd_valid_o(fwd_valid), .busy_o(busy), .done_o(done),
    .error_o(err), .error_code_o(error_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Inputs change just after posedge, so the negedge sees what the next edge will sample
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin obs_tx.push_back(tx_data); n_tx++; last_tx_cyc = cyc; end
    if (fwd_valid) obs_fwd.push_back(fwd_data);
    if (done) n_done++;
    if (err) begin n_err++; last_err_cyc = cyc; end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask
  task automatic accept(input logic [7:0] c, input logic [7:0] a, input logic h);
    for (int i = 0; i < 300 && !cmd_ready; i++) tick(1);
    check("cmd_ready_before_accept", cmd_ready, 1);
    cmd_byte = c; arg_byte = a; has_arg = h; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask
  // kind: 0 tx handshake, 1 done pulse, 2 error pulse, 3 nothing within the bound
  task automatic wait_event(output int kind);
    int t0, d0, e0;
    t0 = n_tx; d0 = n_done; e0 = n_err; kind = 3;
    for (int i = 0; i < 2000 && kind == 3; i++) begin
      tick(1);
      kind = n_tx != t0 ? 0 : n_done != d0 ? 1 : n_err != e0 ? 2 : 3;
    end
  endtask
  // Plays the keyboard: reactions come from script, else random (0 ACK/AA, 1 RESEND/FC, 2 silent)
  task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input logic h, input int junk_pct);
    logic [7:0] exp_tx[$], exp_fwd[$];
    logic [7:0] cur, b;
    int tx0, fwd0, d0, e0, phase, att, r, kind, prev;
    bit fin, exp_ok, gap_final;
    kbd_cmd_err_t exp_code;
    tx0 = obs_tx.size(); fwd0 = obs_fwd.size(); d0 = n_done; e0 = n_err;
    accept(c, a, h);
    check("busy_after_accept", busy, 1);
    check("code_cleared_on_accept", error_code, ERR_NONE);
    phase = 0; att = 0; cur = c; fin = 0; exp_ok = 1; exp_code = ERR_NONE; gap_final = 0;
    exp_tx.push_back(c);
    wait_event(kind);
    check("first_send", kind, 0);
    fin = kind == 3;
    while (!fin) begin
      if ($urandom_range(0, 99) < junk_pct) begin
        b = 8'($urandom_range(0, 8'h7F));
        tick($urandom_range(0, 5));
        send_rx(b);
        exp_fwd.push_back(b);
      end
      r = script.size() > 0 ? script.pop_front() : int'($urandom_range(0, 2));
      tick($urandom_range(0, 8));
      if (phase < 2) begin
        if (r == 0) begin
          send_rx(PS2_ACK);
          att = 0;
          if (phase == 0 && h) begin
            phase = 1; cur = a; exp_tx.push_back(a);
            wait_event(kind);
            check("arg_send", kind, 0);
            fin = kind == 3;
          end else if (phase == 0 && c == KBD_CMD_RESET) begin
            phase = 2;
          end else begin
            fin = 1;
          end
        end else begin
          if (r == 1) send_rx(PS2_RESEND);
          if (att < MAXR) begin
            att++;
            exp_tx.push_back(cur);
            prev = last_tx_cyc;
            wait_event(kind);
            check("retry_send", kind, 0);
            if (r == 2) check("ack_timeout_gap", (last_tx_cyc - prev >= ACK_T) && (last_tx_cyc - prev <= ACK_T + 4), 1);
            fin = kind == 3;
          end else begin
            fin = 1; exp_ok = 0; gap_final = r == 2;
            exp_code = r == 1 ? ERR_RETRIES : ERR_TIMEOUT;
          end
        end
      end else begin
        fin = 1;
        exp_ok = r == 0;
        exp_code = r == 0 ? ERR_NONE : r == 1 ? ERR_BAT : ERR_TIMEOUT;
        if (r < 2) send_rx(r == 0 ? PS2_BAT_OK : PS2_BAT_FAIL);
      end
    end
    prev = last_tx_cyc;
    wait_event(kind);
    check("outcome", kind, exp_ok ? 1 : 2);
    if (gap_final) check("final_timeout_gap", (last_err_cyc - prev >= ACK_T) && (last_err_cyc - prev <= ACK_T + 4), 1);
    tick(1);
    check("error_code", error_code, exp_code);
    check("idle_after_cmd", cmd_ready, 1);
    check("done_pulses", n_done - d0, exp_ok);
    check("error_pulses", n_err - e0, !exp_ok);
    check("tx_count", obs_tx.size() - tx0, exp_tx.size());
    foreach (exp_tx[i]) if (tx0 + i < obs_tx.size()) check("tx_byte", obs_tx[tx0 + i], exp_tx[i]);
    check("fwd_count", obs_fwd.size() - fwd0, exp_fwd.size());
    foreach (exp_fwd[i]) if (fwd0 + i < obs_fwd.size()) check("fwd_byte", obs_fwd[fwd0 + i], exp_fwd[i]);
  endtask
  initial begin
    int kind, d0, e0, sel;
    logic [7:0] c;
    reset = 1'b1; cmd_valid = 1'b0; cmd_byte = '0; arg_byte = '0; has_arg = 1'b0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
    tick(3);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", err, 0);
    check("rst_code", error_code, ERR_NONE);
    reset = 1'b0;
    tick(2);
    script = '{0, 0};       run_cmd(KBD_CMD_SET_LEDS, 8'h07, 1'b1, 0);
    script = '{0, 0};       run_cmd(KBD_CMD_RESET, 8'h00, 1'b0, 0);
    script = '{0, 1};       run_cmd(KBD_CMD_RESET, 8'h00, 1'b0, 0);
    script = '{0, 2};       run_cmd(KBD_CMD_RESET, 8'h00, 1'b0, 0);
    script = '{1, 1, 0};    run_cmd(8'hF4, 8'h00, 1'b0, 0);
    script = '{1, 1, 1, 1}; run_cmd(8'hF4, 8'h00, 1'b0, 0);
    script = '{2, 2, 2, 2}; run_cmd(8'hF4, 8'h00, 1'b0, 0);
    script = '{0, 1, 1, 0}; run_cmd(KBD_CMD_SET_LEDS, 8'h02, 1'b1, 100);
    // Non-protocol byte while waiting for ACK: forwarded one cycle later, sequence continues
    accept(8'hF4, 8'h00, 1'b0);
    wait_event(kind);
    check("il_send", kind, 0);
    send_rx(8'h1C);
    check("il_fwd_valid", fwd_valid, 1);
    check("il_fwd_data", fwd_data, 8'h1C);
    check("il_still_busy", busy, 1);
    check("il_no_resend", tx_valid, 0);
    tick(1);
    check("il_fwd_pulse_1cyc", fwd_valid, 0);
    send_rx(PS2_ACK);
    check("il_ack_consumed", fwd_valid, 0);
    wait_event(kind);
    check("il_done", kind, 1);
    tick(2);
    send_rx(PS2_ACK);
    check("idle_ack_fwd_valid", fwd_valid, 1);
    check("idle_ack_fwd_data", fwd_data, PS2_ACK);
    send_rx(PS2_BAT_OK);
    check("idle_aa_fwd_data", {fwd_valid, fwd_data}, {1'b1, PS2_BAT_OK});
    tick(1);
    // Transmitter stall: request and byte held stable, then abort by reset
    tx_ready = 1'b0;
    accept(8'hF3, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("stall_tx_valid", tx_valid, 1);
      check("stall_tx_data", tx_data, 8'hF3);
      tick(1);
    end
    d0 = n_done; e0 = n_err;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tx_ready = 1'b1;
    check("abort_send_tx_valid", tx_valid, 0);
    check("abort_send_ready", cmd_ready, 1);
    // Reset while waiting for the argument ACK
    accept(KBD_CMD_SET_LEDS, 8'h05, 1'b1);
    wait_event(kind);
    tick(2);
    send_rx(PS2_ACK);
    wait_event(kind);
    check("abort_arg_sent", kind, 0);
    check("abort_arg_byte", obs_tx[obs_tx.size() - 1], 8'h05);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_wait_ready", cmd_ready, 1);
    check("abort_wait_tx_valid", tx_valid, 0);
    check("abort_wait_busy", busy, 0);
    tick(ACK_T + 20);
    check("abort_no_done", n_done - d0, 0);
    check("abort_no_error", n_err - e0, 0);
    script.delete();
    for (int k = 0; k < 25; k++) begin
      sel = $urandom_range(0, 3);
      c = sel == 0 ? KBD_CMD_SET_LEDS : sel == 1 ? KBD_CMD_RESET : sel == 2 ? 8'hF4 : 8'($urandom);
      run_cmd(c, 8'($urandom), 1'($urandom_range(0, 1)), 40);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
